// File: rtl/lsu_pkg.sv
// Shared types and the load-lane extraction helper for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } lsu_size_t;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_ISSUE   = 3'd1,
        RD_CAPTURE = 3'd2,
        WR         = 3'd3,
        RESP       = 3'd4
    } lsu_state_t;

    // Picks the addressed lane of a little-endian word and sign/zero extends it.
    function automatic logic [31:0] lsu_extend(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  offset,
                                               input logic        is_unsigned);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        shifted = word >> {offset, 3'b000};
        b = shifted[7:0];
        h = offset[1] ? word[31:16] : word[15:0];
        case (size)
            BYTE:    r = {{24{b[7] & ~is_unsigned}}, b};
            HALF:    r = {{16{h[15] & ~is_unsigned}}, h};
            WORD:    r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Byte-enable generation and store-data merge for sub-word read-modify-write.
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    output logic [31:0] merged_word
);

    logic [3:0]  byte_en_s;
    logic [31:0] lane_data_s;

    // Replicate store data across lanes, then keep only the enabled bytes.
    always_comb begin
        byte_en_s   = 4'b0000;
        lane_data_s = 32'h0000_0000;
        merged_word = old_word;
        case (size)
            BYTE: begin
                byte_en_s   = 4'b0001 << offset;
                lane_data_s = {4{store_data[7:0]}};
            end
            HALF: begin
                byte_en_s   = offset[1] ? 4'b1100 : 4'b0011;
                lane_data_s = {2{store_data[15:0]}};
            end
            WORD: begin
                byte_en_s   = 4'b1111;
                lane_data_s = store_data;
            end
            default: begin
                byte_en_s   = 4'b0000;
                lane_data_s = 32'h0000_0000;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            merged_word[8*i +: 8] = byte_en_s[i] ? lane_data_s[8*i +: 8] : old_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a one-cycle-latency word memory.
// Define LSU_SUBWORD_EN to enable byte/half accesses (sub-word stores use read-modify-write).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    lsu_state_t  state_r, next_state_s;
    logic        accept_s, fault_s, size_fault_s, misaligned_s, out_of_range_s;
    logic        write_r, unsigned_r;
    logic [1:0]  size_r, offset_r;
    logic        mem_write_r, rsp_valid_r, rsp_fault_r;
    logic [31:0] mem_address_r, mem_write_data_r, rsp_rdata_r;

`ifdef LSU_SUBWORD_EN
    logic [31:0] wdata_r;
    logic [31:0] merged_s;

    lsu_lane_merge u_lane_merge (
        .size        (size_r),
        .offset      (offset_r),
        .old_word    (mem_read_data),
        .store_data  (wdata_r),
        .merged_word (merged_s)
    );
`endif

    // Request legality checks, evaluated on the incoming request.
    always_comb begin
        accept_s       = req_valid && (state_r == IDLE);
`ifdef LSU_SUBWORD_EN
        size_fault_s   = (req_size == 2'b11);
`else
        size_fault_s   = (req_size != WORD);
`endif
        misaligned_s   = ((req_size == HALF) && req_addr[0]) ||
                         ((req_size == WORD) && (req_addr[1:0] != 2'b00));
        out_of_range_s = ((req_addr >> (INDEX_BITS + 2)) != 32'd0);
        fault_s        = size_fault_s || misaligned_s || out_of_range_s;
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    next_state_s = IDLE;
                end else if (fault_s) begin
                    next_state_s = RESP;
                end else if (req_write && (req_size == WORD)) begin
                    next_state_s = WR;
                end else begin
                    next_state_s = RD_ISSUE;
                end
            end
            RD_ISSUE: next_state_s = RD_CAPTURE;
            RD_CAPTURE: begin
`ifdef LSU_SUBWORD_EN
                if (write_r) begin
                    next_state_s = WR;
                end else begin
                    next_state_s = RESP;
                end
`else
                next_state_s = RESP;
`endif
            end
            WR:      next_state_s = RESP;
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request capture on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_r    <= 1'b0;
            unsigned_r <= 1'b0;
            size_r     <= 2'b00;
            offset_r   <= 2'b00;
`ifdef LSU_SUBWORD_EN
            wdata_r    <= 32'h0000_0000;
`endif
        end else if (accept_s) begin
            write_r    <= req_write;
            unsigned_r <= req_unsigned;
            size_r     <= req_size;
            offset_r   <= req_addr[1:0];
`ifdef LSU_SUBWORD_EN
            wdata_r    <= req_wdata;
`endif
        end
    end

    // Registered memory-side and response outputs, decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_write_r      <= 1'b0;
            mem_address_r    <= 32'h0000_0000;
            mem_write_data_r <= 32'h0000_0000;
            rsp_valid_r      <= 1'b0;
            rsp_fault_r      <= 1'b0;
            rsp_rdata_r      <= 32'h0000_0000;
        end else begin
            mem_write_r <= (next_state_s == WR);
            rsp_valid_r <= (next_state_s == RESP);
            rsp_fault_r <= accept_s && fault_s;
            rsp_rdata_r <= ((state_r == RD_CAPTURE) && !write_r) ?
                           lsu_extend(mem_read_data, size_r, offset_r, unsigned_r) : 32'h0000_0000;
            if (accept_s && !fault_s) begin
                mem_address_r <= {req_addr[31:2], 2'b00};
                if (req_write && (req_size == WORD)) begin
                    mem_write_data_r <= req_wdata;
                end
            end
`ifdef LSU_SUBWORD_EN
            // Sub-word store: fold the new lane into the word just read.
            else if ((state_r == RD_CAPTURE) && write_r) begin
                mem_write_data_r <= merged_s;
            end
`endif
        end
    end

    assign req_ready      = (state_r == IDLE);
    assign rsp_valid      = rsp_valid_r;
    assign rsp_fault      = rsp_fault_r;
    assign rsp_rdata      = rsp_rdata_r;
    assign mem_write      = mem_write_r;
    assign mem_address    = mem_address_r;
    assign mem_write_data = mem_write_data_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural memory and reference model.
module tb_load_store_unit;

`ifdef LSU_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, rsp_valid, rsp_fault, mem_write;
    logic [31:0] rsp_rdata, mem_address, mem_write_data;
    logic [31:0] mem_read_data = 32'h0;

    logic [31:0] ram       [0:4095];
    logic [31:0] model_mem [0:4095];

    int checks = 0;
    int errors = 0;

    int          lat, nwr, wcyc, waitc;
    logic [31:0] r_rdata;
    logic        r_fault;

    load_store_unit #(.INDEX_BITS(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // data_memory: synchronous one-cycle read, full-word write
    always @(posedge clk) begin
        if (mem_write) ram[mem_address[13:2]] <= mem_write_data;
        mem_read_data <= ram[mem_address[13:2]];
    end

    // ---------------- reference model ----------------
    function automatic bit m_fault(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (!SUB && sz != 2'd2) return 1'b1;
        if (a >= 32'h0000_4000) return 1'b1;
        if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_latency(input logic w, input logic [1:0] sz, input logic [31:0] a);
        if (m_fault(sz, a)) return 1;
        if (!w) return 3;
        if (sz == 2'd2) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] m_mask(input logic [1:0] sz);
        if (sz == 2'd0) return 32'h0000_00FF;
        if (sz == 2'd1) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        logic [31:0] v;
        logic [31:0] mask;
        mask = m_mask(sz);
        v = (model_mem[a / 4] >> ((a % 4) * 8)) & mask;
        if (!uns && ((v & ((mask >> 1) + 32'd1)) != 32'd0)) v = v | ~mask;
        return v;
    endfunction

    task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] mask;
        int          sh;
        mask = m_mask(sz);
        sh = (a % 4) * 8;
        model_mem[a / 4] = (model_mem[a / 4] & ~(mask << sh)) | ((d & mask) << sh);
    endtask

    // ---------------- driver / observer ----------------
    task automatic run_req(input logic w, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] d);
        waitc = 0;
        @(negedge clk);
        while (!req_ready && waitc < 20) begin
            waitc++;
            @(negedge clk);
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = d;
        @(posedge clk);
        lat = 0; nwr = 0; wcyc = 0; r_rdata = 32'h0; r_fault = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_write) begin
                nwr++;
                wcyc = n;
            end
            if (rsp_valid) begin
                lat = n;
                r_rdata = rsp_rdata;
                r_fault = rsp_fault;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_fault, mem_write} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 1000", {req_ready, rsp_valid, rsp_fault, mem_write});
        end
        checks++;
        if ({rsp_rdata, mem_address, mem_write_data} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {rsp_rdata, mem_address, mem_write_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word_round_trip;
        run_req(1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'hFEED_FACE);
        m_store(2'd2, 32'h0000_1000, 32'hFEED_FACE);
        checks++;
        if ({lat, r_fault, nwr, wcyc} !== {32'd2, 1'b0, 32'd1, 32'd1}) begin
            errors++;
            $display("FAIL word_store: lat/fault/writes/wcycle %0d/%0b/%0d/%0d expected 2/0/1/1", lat, r_fault, nwr, wcyc);
        end
        checks++;
        if (ram[12'h400] !== 32'hFEED_FACE) begin
            errors++;
            $display("FAIL word_store_ram: got %h expected feedface", ram[12'h400]);
        end
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0);
        checks++;
        if ({lat, r_fault, nwr, r_rdata} !== {32'd3, 1'b0, 32'd0, 32'hFEED_FACE}) begin
            errors++;
            $display("FAIL word_load: lat/fault/writes/data %0d/%0b/%0d/%h expected 3/0/0/feedface", lat, r_fault, nwr, r_rdata);
        end
    endtask

    task automatic test_byte_merge;
        logic [31:0] exp_word;
        ram[12'h400] = 32'h1122_3344;
        model_mem[12'h400] = 32'h1122_3344;
        exp_word = SUB ? 32'h1122_AB44 : 32'h1122_3344;
        run_req(1'b1, 2'd0, 1'b0, 32'h0000_1001, 32'h5A5A_5AAB);
        if (!m_fault(2'd0, 32'h0000_1001)) m_store(2'd0, 32'h0000_1001, 32'h5A5A_5AAB);
        checks++;
        if ({lat, nwr, wcyc} !== {m_latency(1'b1, 2'd0, 32'h1001), SUB ? 32'd1 : 32'd0, SUB ? 32'd3 : 32'd0}) begin
            errors++;
            $display("FAIL byte_store_timing: lat/writes/wcycle %0d/%0d/%0d", lat, nwr, wcyc);
        end
        checks++;
        if (ram[12'h400] !== exp_word) begin
            errors++;
            $display("FAIL byte_store_ram: got %h expected %h", ram[12'h400], exp_word);
        end
    endtask

    task automatic test_byte_load_ext;
        run_req(1'b0, 2'd0, 1'b0, 32'h0000_1001, 32'h0);
        checks++;
        if ({r_rdata, r_fault, lat} !== {SUB ? 32'hFFFF_FFAB : 32'h0, !SUB, SUB ? 32'd3 : 32'd1}) begin
            errors++;
            $display("FAIL byte_load_signed: data/fault/lat %h/%0b/%0d", r_rdata, r_fault, lat);
        end
        run_req(1'b0, 2'd0, 1'b1, 32'h0000_1001, 32'h0);
        checks++;
        if ({r_rdata, r_fault, lat} !== {SUB ? 32'h0000_00AB : 32'h0, !SUB, SUB ? 32'd3 : 32'd1}) begin
            errors++;
            $display("FAIL byte_load_unsigned: data/fault/lat %h/%0b/%0d", r_rdata, r_fault, lat);
        end
    endtask

    task automatic test_faults;
        run_req(1'b0, 2'd1, 1'b0, 32'h0000_1003, 32'h0);
        checks++;
        if ({lat, r_fault, nwr, r_rdata} !== {32'd1, 1'b1, 32'd0, 32'h0}) begin
            errors++;
            $display("FAIL fault_misaligned_half: lat/fault/writes/data %0d/%0b/%0d/%h expected 1/1/0/0", lat, r_fault, nwr, r_rdata);
        end
        run_req(1'b1, 2'd2, 1'b0, 32'h0000_4000, 32'h1234_5678);
        checks++;
        if ({lat, r_fault, nwr, r_rdata} !== {32'd1, 1'b1, 32'd0, 32'h0}) begin
            errors++;
            $display("FAIL fault_out_of_range: lat/fault/writes/data %0d/%0b/%0d/%h expected 1/1/0/0", lat, r_fault, nwr, r_rdata);
        end
    endtask

    task automatic test_reset_mid_write;
        int pulses;
        ram[1] = 32'h0BAD_F00D;
        model_mem[1] = 32'h0BAD_F00D;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0000_0004; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL wr_cycle_before_reset: mem_write %b expected 1", mem_write);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_fault, mem_write, rsp_rdata, mem_address, mem_write_data}
                !== {4'b1000, 96'h0}) begin
            errors++;
            $display("FAIL reset_mid_write: ctrl %b addr %h wdata %h", {req_ready, rsp_valid, rsp_fault, mem_write}, mem_address, mem_write_data);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_no_response: got %0d pulses expected 0", pulses);
        end
        checks++;
        if (ram[1] !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL reset_write_dropped: ram[1] %h expected 0badf00d", ram[1]);
        end
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0);
        checks++;
        if ({waitc, lat, r_rdata} !== {32'd0, 32'd3, 32'h0BAD_F00D}) begin
            errors++;
            $display("FAIL after_reset_load: wait/lat/data %0d/%0d/%h expected 0/3/0badf00d", waitc, lat, r_rdata);
        end
    endtask

    task automatic test_back_to_back;
        logic        w, uns, ef;
        logic [1:0]  sz;
        logic [31:0] a, d, erd;
        int          el, idx;
        for (int it = 0; it < 80; it++) begin
            w   = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            a   = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 16383));
            if (sz == 2'd2 && $urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
            d   = $urandom;
            ef  = m_fault(sz, a);
            el  = m_latency(w, sz, a);
            erd = (!w && !ef) ? m_load(sz, uns, a) : 32'h0;
            run_req(w, sz, uns, a, d);
            checks++;
            if ({waitc, lat, r_fault, r_rdata, nwr} !== {32'd0, el, ef, erd, (w && !ef) ? 32'd1 : 32'd0}) begin
                errors++;
                $display("FAIL random[%0d] w=%0b sz=%0d a=%h: wait %0d lat %0d/%0d fault %0b/%0b data %h/%h writes %0d",
                         it, w, sz, a, waitc, lat, el, r_fault, ef, r_rdata, erd, nwr);
            end
            if (w && !ef) begin
                m_store(sz, a, d);
                idx = int'(a / 4);
                checks++;
                if (ram[idx] !== model_mem[idx]) begin
                    errors++;
                    $display("FAIL random_ram[%0d] a=%h: got %h expected %h", it, a, ram[idx], model_mem[idx]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i] = $urandom;
            model_mem[i] = ram[i];
        end
        test_reset();
        test_word_round_trip();
        test_byte_merge();
        test_byte_load_ext();
        test_faults();
        test_reset_mid_write();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
